// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings, default width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             din,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor keeps shifted below 2*divisor, so bit WIDTH of diff is a clean borrow flag
  assign shifted = {rem, din};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_nxt = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO, with MTHI/MTLO writes.
// Optional MDU_EARLY_TERM_EN: multiply stops once the remaining multiplier is zero.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             HEN,
  input  logic             LEN,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             wr_err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state, state_nxt;
  mdu_op_e            op_q;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q, sa_q;
  logic [WIDTH-1:0]   opa, opb, rs_lat;
  logic [2*WIDTH-1:0] acc;

  logic               sa_in, sb_in;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   rem_nxt;
  logic               q_bit;
  logic               calc_last;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign busy  = (state == CALC) || (state == FIX);
  assign sa_in = ~op[0] & rs_val[WIDTH-1];
  assign sb_in = ~op[0] & rt_val[WIDTH-1];

  // multiply: add multiplicand into the upper half, then shift the whole accumulator right
  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (acc[2*WIDTH-1:WIDTH]),
    .divisor (opa),
    .din     (opb[WIDTH-1]),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
    calc_last = (cnt == CNT_W'(WIDTH-1));
`ifdef MDU_EARLY_TERM_EN
    if (!op_q[1] && (opb[WIDTH-1:1] == '0))
      calc_last = 1'b1;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (calc_last) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

`ifdef MDU_EARLY_TERM_EN
  logic [CNT_W:0] align_sh;
  assign align_sh = (CNT_W+1)'(WIDTH) - {1'b0, cnt};
`endif

  always_comb begin
    prod = acc;
`ifdef MDU_EARLY_TERM_EN
    // after n steps the product sits WIDTH-n bits too high
    prod = acc >> align_sh;
`endif
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_s  = sa_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q     <= MDU_MULT;
      cnt      <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      rs_lat   <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      done     <= (state == FIX);
      div_zero <= (state == FIX) && op_q[1] && (opa == '0);
      wr_err   <= busy && (start || HEN || LEN);
      case (state)
        IDLE: begin
          if (HEN) hi <= rs_val;
          if (LEN) lo <= rs_val;
          if (start) begin
            op_q   <= mdu_op_e'(op);
            cnt    <= '0;
            neg_q  <= sa_in ^ sb_in;
            sa_q   <= sa_in;
            opa    <= sb_in ? -rt_val : rt_val;
            opb    <= sa_in ? -rs_val : rs_val;
            rs_lat <= rs_val;
            acc    <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q[1]) begin
            acc <= {rem_nxt, acc[WIDTH-2:0], q_bit};
            opb <= {opb[WIDTH-2:0], 1'b0};
          end else begin
            acc <= {add_sum, acc[WIDTH-1:1]};
            opb <= {1'b0, opb[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (op_q[1]) begin
            if (opa == '0) begin
              hi <= rs_lat;
              lo <= '1;
            end else begin
              hi <= rem_s;
              lo <= quo_s;
            end
          end else begin
            hi <= prod_s[2*WIDTH-1:WIDTH];
            lo <= prod_s[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised bench for mult_div_unit against a transaction-level arithmetic model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST, start, HEN, LEN;
  logic [1:0]   op;
  logic [W-1:0] rs_val, rt_val;
  logic         busy, done, div_zero, wr_err;
  logic [W-1:0] hi, lo;

  always #5 CLK = ~CLK;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .HEN(HEN), .LEN(LEN), .busy(busy), .done(done), .div_zero(div_zero),
    .wr_err(wr_err), .hi(hi), .lo(lo)
  );

  int nvec = 0;
  int nerr = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // expected result and edges from sampling start to the hi/lo update
  function automatic void predict(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l,
                                  output logic dz, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] u;
    dz  = 1'b0;
    lat = W + 1;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    u   = '0;
    case (o)
      2'b00: u = 64'(sa * sb);
      2'b01: u = {32'b0, a} * {32'b0, b};
      2'b10: if (b != 0) begin
               q = sa / sb;
               r = sa % sb;
               u = {32'(r), 32'(q)};
             end
      default: if (b != 0) u = {32'(a % b), 32'(a / b)};
    endcase
    h = u[63:32];
    l = u[31:0];
    if (o[1] && b == 0) begin
      h  = a;
      l  = '1;
      dz = 1'b1;
    end
`ifdef MDU_EARLY_TERM_EN
    if (!o[1]) begin
      logic [W-1:0] mag;
      int n;
      mag = (!o[0] && b[W-1]) ? -b : b;
      n = 1;
      for (int i = 1; i < W; i++) if ((mag >> i) != 0) n = i + 1;
      lat = n + 1;
    end
`endif
  endfunction

  // model: 0 idle, 1 busy, 2 done
  int           m_phase = 0, m_cnt = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  logic         m_done = 0, m_dz = 0, m_werr = 0, r_dz = 0;
  bit           armed = 0;

  always @(posedge CLK) begin
    armed = 1;
    if (RST) begin
      m_phase = 0; m_hi = '0; m_lo = '0;
      m_done = 0; m_dz = 0; m_werr = 0;
    end else begin
      m_done = 0; m_dz = 0; m_werr = 0;
      case (m_phase)
        0: begin
          if (HEN) m_hi = rs_val;
          if (LEN) m_lo = rs_val;
          if (start) begin
            predict(op, rs_val, rt_val, r_hi, r_lo, r_dz, m_cnt);
            m_phase = 1;
          end
        end
        1: begin
          if (start || HEN || LEN) m_werr = 1;
          m_cnt--;
          if (m_cnt == 0) begin
            m_hi = r_hi; m_lo = r_lo; m_done = 1; m_dz = r_dz; m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (armed) begin
      chk("busy", busy, m_phase == 1);
      chk("done", done, m_done);
      chk("div_zero", div_zero, m_dz);
      chk("wr_err", wr_err, m_werr);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                       input string nm, output int n);
    op = o; rs_val = a; rt_val = b; start = 1;
    tick();
    start = 0;
    wait_done(n);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    chk({nm, "_dz"}, div_zero, edz);
    tick();
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    RST = 1; start = 0; HEN = 0; LEN = 0; op = 2'b00; rs_val = '0; rt_val = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    RST = 0;
    tick();

    HEN = 1; rs_val = 32'h1234;
    tick();
    HEN = 0;
    chk("mthi", hi, 32'h1234);

    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, "mult", n);
`ifndef MDU_EARLY_TERM_EN
    chk("mult_latency", n, 34);
`endif
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0, "multu", n);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "div_neg", n);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, "div_ovf", n);
    do_op(2'b11, 32'h64, 32'h0, 32'h64, 32'hFFFF_FFFF, 1, "divu_zero", n);

    // MTHI while busy is dropped and flagged
    op = 2'b00; rs_val = 32'd3; rt_val = 32'hFFFF_0005; start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    HEN = 1; rs_val = 32'hDEAD;
    tick();
    HEN = 0;
    chk("wr_err_pulse", wr_err, 1);
    chk("wr_err_hi_kept", hi, 32'h64);
    wait_done(n);
    chk("busy_mult_hi", hi, 32'hFFFF_FFFF);
    chk("busy_mult_lo", lo, 32'hFFFD_000F);
    tick();

    // reset mid-divide aborts, then a new start is taken immediately
    op = 2'b10; rs_val = 32'd100; rt_val = 32'd7; start = 1;
    tick();
    start = 0;
    repeat (10) tick();
    RST = 1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_done", done, 0);
    RST = 0; op = 2'b01; rs_val = 32'd2; rt_val = 32'd3; start = 1;
    tick();
    start = 0;
    chk("restart_busy", busy, 1);
    wait_done(n);
    chk("restart_lo", lo, 32'd6);
    tick();

    for (int i = 0; i < 4000; i++) begin
      RST    = ($urandom_range(0, 799) == 0);
      start  = ($urandom_range(0, 5) == 0);
      HEN    = ($urandom_range(0, 15) == 0);
      LEN    = ($urandom_range(0, 15) == 0);
      op     = 2'($urandom_range(0, 3));
      rs_val = rnd_val();
      rt_val = rnd_val();
      tick();
    end
    RST = 0; start = 0; HEN = 0; LEN = 0;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
